nf_uart_receiver: RTL and testbench
===================================

// Module: nf_uart_receiver
// PURPOSE
// - UART 8N1 receiver; consumes the serial stream nf_uart_transmitter produces (loopback partner).
// - Samples uart_rx at mid-bit using the same comp baud setting, assembles LSB-first bytes.
// - Presents each byte to the controller via a valid/ack handshake; flags framing and overrun.
// PARAMETERS
// - none; data width fixed at 8, one stop bit, no parity.
// PORTS
// clk       in   1   clock
// resetn    in   1   reset, asynchronous, active-low
// rec_en    in   1   receiver enable; low forces IDLE and discards any partial frame
// comp      in   16  bit period minus one, in clk cycles (bit period = comp+1)
// uart_rx   in   1   serial input; asynchronous to clk
// rx_data   out  8   last received byte
// rx_valid  out  1   rx_data holds an unacknowledged byte
// rx_ack    in   1   controller consumed rx_data
// rx_ferr   out  1   stop bit of the byte in rx_data sampled low
// rx_ovr    out  1   sticky: a byte was overwritten before rx_ack
// BEHAVIOUR
// - Reset: rx_data=0, rx_valid=0, rx_ferr=0, rx_ovr=0, state IDLE, counters 0, sync flops=1.
// - uart_rx passes a 2-flop synchronizer (reset 1); rx_s = synchronized value, rx_p = rx_s delayed 1.
// - 16-bit counter; "tick" = counter >= comp, counter cleared on tick, else +1.
// - FSM states: IDLE, START, RECEIVE, STOP.
//   IDLE:    start edge (rx_p==1 && rx_s==0) -> START, counter=0, bit_counter=0.
//            Line held low (break) never retriggers: requires a 1->0 edge.
//   START:   when counter >= (comp>>1): rx_s==0 -> RECEIVE, counter=0; rx_s==1 -> IDLE (glitch).
//   RECEIVE: on tick shift rx_s into bit[bit_counter] (LSB first), bit_counter+1;
//            tick with bit_counter==7 -> STOP.
//   STOP:    on tick: rx_data<=shift reg, rx_ferr<=~rx_s, rx_valid<=1, -> IDLE.
// - Handshake: rx_valid held until a cycle with rx_ack=1; that cycle clears rx_valid and rx_ovr.
//   rx_ack with rx_valid=0 has no effect.
// - Simultaneous STOP completion and rx_ack: new byte wins; rx_valid stays 1, rx_ovr stays 0.
// - STOP completion with rx_valid=1 and no rx_ack: rx_data/rx_ferr overwritten, rx_ovr<=1.
// - rx_ferr describes the byte currently in rx_data; byte is still delivered.
// - Latency: rx_valid rises 1 cycle after the STOP-state tick; from uart_rx falling edge at pin
//   = 2 (sync) + 1 (edge) + (comp>>1)+1 + 9*(comp+1) cycles, +/-1 for pin phase.
// - rec_en=0: state->IDLE, counter/bit_counter/shift reg cleared; rx_data/rx_valid/flags retained;
//   rx_ack still honoured. Re-enable needs a fresh start edge.
// - comp change mid-frame: takes effect immediately; >= compares guarantee no wrap or hang.
// - comp < 3 unsupported for correct data; FSM must still advance and return to IDLE.
// - Reset mid-frame: immediate return to reset values, no spurious rx_valid.
// STRUCTURE
// - nf_uart_pkg: receiver state enum (shared with transmitter state type), 8N1 constants
//   (data bits = 8, stop bits = 1).
// - Sub-module nf_uart_rx_sync: 2-flop synchronizer + falling-edge detect, outputs rx_s, start_edge.
// - Top: FSM, baud counter, bit counter, shift reg, output/handshake regs.
// TESTING
// - comp=15, loopback from nf_uart_transmitter sending 0xA5 -> rx_valid=1, rx_data=0xA5,
//   rx_ferr=0, within 2+1+8+144 +/-1 cycles of tx start edge.
// - Back-to-back 0x00,0xFF,0x55 with rx_ack each byte -> three valid pulses, correct data, rx_ovr=0.
// - Two bytes, no rx_ack -> rx_data=second byte, rx_ovr=1; then rx_ack -> rx_valid=0, rx_ovr=0.
// - comp=15, stop bit driven low for 0x3C -> rx_data=0x3C, rx_ferr=1; held-low line -> no retrigger.
// - 4-cycle low glitch on idle line (comp=15) -> back to IDLE, no rx_valid.
// - rec_en dropped at bit 4, restored, full 0x81 sent -> only 0x81 received; resetn pulse
//   mid-frame -> all outputs 0, no rx_valid.

Source files
------------

// File: rtl/nf_uart_pkg.sv
// Shared UART types and 8N1 framing constants for the nf_uart transmitter/receiver pair.
package nf_uart_pkg;

  // Serial framing: 8 data bits, one stop bit, no parity.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int CNT_W     = 16;

  // Frame phase, common to both directions of the link.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RECEIVE = 2'd2,
    STOP    = 2'd3
  } uart_state_e;

  // Mid-bit sample offset used to qualify a start bit.
  function automatic logic [CNT_W-1:0] half_period(input logic [CNT_W-1:0] comp);
    return comp >> 1;
  endfunction

endpackage

// File: rtl/nf_uart_rx_sync.sv
// Brings the asynchronous serial line into the clk domain and flags 1->0 transitions.
module nf_uart_rx_sync
  import nf_uart_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic uart_rx_i,
  output logic rx_s_o,
  output logic start_edge_o
);

  logic meta_q;
  logic rx_s_q;
  logic rx_p_q;

  // Two-flop synchronizer plus one delay stage; reset to the idle (mark) level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_p_q <= 1'b1;
    end else begin
      meta_q <= uart_rx_i;
      rx_s_q <= meta_q;
      rx_p_q <= rx_s_q;
    end
  end

  assign rx_s_o       = rx_s_q;
  // Only a genuine falling edge counts; a line held low never retriggers.
  assign start_edge_o = rx_p_q & ~rx_s_q;

endmodule

// File: rtl/nf_uart_receiver.sv
// UART 8N1 receiver: mid-bit sampling, LSB-first assembly, valid/ack handoff with
// framing-error and sticky overrun flags.
module nf_uart_receiver
  import nf_uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rec_en,
  input  logic [CNT_W-1:0]     comp,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_ferr,
  output logic                 rx_ovr
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_s;
  logic start_edge;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;

  logic tick;
  logic deliver;
  logic ack_hit;

  nf_uart_rx_sync u_sync (
    .clk          (clk),
    .resetn       (resetn),
    .uart_rx_i    (uart_rx),
    .rx_s_o       (rx_s),
    .start_edge_o (start_edge)
  );

  // >= rather than == so a comp reduced mid-bit can never be skipped past.
  assign tick    = (cnt_q >= comp);
  assign ack_hit = rx_ack & rx_valid_q;

  // Frame FSM, baud counter, bit counter and shift register next-state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    if (!rec_en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          if (start_edge) state_d = START;
        end
        START: begin
          if (cnt_q >= half_period(comp)) begin
            cnt_d   = '0;
            // A line back high at mid start bit was a glitch.
            state_d = rx_s ? IDLE : RECEIVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RECEIVE: begin
          if (tick) begin
            cnt_d              = '0;
            shift_d[bit_cnt_q] = rx_s;
            bit_cnt_d          = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            cnt_d   = '0;
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output handoff: a completing byte beats a same-cycle ack; an unacked byte being replaced sets overrun.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_ferr_d  = rx_ferr_q;
    rx_valid_d = rx_valid_q & ~ack_hit;
    rx_ovr_d   = rx_ovr_q & ~ack_hit;
    if (deliver) begin
      rx_data_d  = shift_q;
      rx_ferr_d  = ~rx_s;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !ack_hit) rx_ovr_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_ferr  = rx_ferr_q;
  assign rx_ovr   = rx_ovr_q;

endmodule

// File: tb/tb_nf_uart_receiver.sv
// Directed bench for nf_uart_receiver: drives 8N1 frames bit by bit and checks the handoff.
module tb_nf_uart_receiver;
  import nf_uart_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rec_en = 1'b0;
  logic [15:0] comp = 16'd15;
  logic        uart_rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack = 1'b0;
  logic        rx_ferr;
  logic        rx_ovr;

  int total = 0;
  int bad = 0;

  int         rises = 0;
  int         rise_cyc = -1;
  int         frame_cyc = 0;
  logic       rise_ferr = 1'b0;
  logic       valid_prev = 1'b0;
  logic [7:0] got_q[$];

  nf_uart_receiver dut (
    .clk      (clk),
    .resetn   (resetn),
    .rec_en   (rec_en),
    .comp     (comp),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .rx_ferr  (rx_ferr),
    .rx_ovr   (rx_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: observe outputs, then drive line/ack for the next edge.
  task automatic step(input logic rxv, input bit auto_ack);
    if (rx_valid && !valid_prev) begin
      rises++;
      rise_cyc  = frame_cyc;
      rise_ferr = rx_ferr;
      got_q.push_back(rx_data);
    end
    valid_prev = rx_valid;
    rx_ack  = auto_ack && rx_valid;
    uart_rx = rxv;
    @(negedge clk);
    frame_cyc++;
  endtask

  task automatic idle(input int n, input logic rxv, input bit auto_ack);
    for (int i = 0; i < n; i++) step(rxv, auto_ack);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit auto_ack);
    logic [9:0] bits;
    bits = {stop_b, d, 1'b0};
    frame_cyc = 0;
    for (int b = 0; b < 10; b++)
      for (int c = 0; c <= int'(comp); c++) step(bits[b], auto_ack);
  endtask

  task automatic clear_log();
    rises = 0;
    rise_cyc = -1;
    got_q.delete();
  endtask

  initial begin
    @(negedge clk);
    // Reset values
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_rx_ferr", 32'(rx_ferr), 32'h0);
    check("rst_rx_ovr", 32'(rx_ovr), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    rec_en = 1'b1;
    idle(10, 1'b1, 1'b0);

    // Single byte 0xA5, latency from line falling edge
    clear_log();
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(10, 1'b1, 1'b0);
    $display("a5 frame: rises=%0d rise_cyc=%0d", rises, rise_cyc);
    check("a5_rises", 32'(rises), 32'd1);
    check("a5_data", 32'(got_q[0]), 32'hA5);
    check("a5_ferr", 32'(rise_ferr), 32'h0);
    check("a5_latency_window", 32'((rise_cyc >= 154) && (rise_cyc <= 156)), 32'h1);
    check("a5_valid_held", 32'(rx_valid), 32'h1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("a5_ack_clears_valid", 32'(rx_valid), 32'h0);
    check("a5_data_retained", 32'(rx_data), 32'hA5);

    // Ack with nothing pending does nothing
    step(1'b1, 1'b0);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("idle_ack_valid", 32'(rx_valid), 32'h0);
    check("idle_ack_ovr", 32'(rx_ovr), 32'h0);

    // Back-to-back 0x00, 0xFF, 0x55 with ack
    clear_log();
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    idle(20, 1'b1, 1'b1);
    $display("b2b frames: rises=%0d", rises);
    check("b2b_rises", 32'(rises), 32'd3);
    check("b2b_byte0", 32'(got_q[0]), 32'h00);
    check("b2b_byte1", 32'(got_q[1]), 32'hFF);
    check("b2b_byte2", 32'(got_q[2]), 32'h55);
    check("b2b_ovr", 32'(rx_ovr), 32'h0);

    // Overrun: two bytes without ack
    clear_log();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(20, 1'b1, 1'b0);
    $display("overrun frames: data=0x%0h ovr=%0b", rx_data, rx_ovr);
    check("ovr_data", 32'(rx_data), 32'h22);
    check("ovr_flag", 32'(rx_ovr), 32'h1);
    check("ovr_valid", 32'(rx_valid), 32'h1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("ovr_ack_valid", 32'(rx_valid), 32'h0);
    check("ovr_ack_flag", 32'(rx_ovr), 32'h0);

    // Framing error on 0x3C, then line held low (no retrigger)
    clear_log();
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(200, 1'b0, 1'b1);
    $display("ferr frame: rises=%0d", rises);
    check("ferr_rises", 32'(rises), 32'd1);
    check("ferr_data", 32'(got_q[0]), 32'h3C);
    check("ferr_flag_at_delivery", 32'(rise_ferr), 32'h1);
    check("ferr_flag_retained", 32'(rx_ferr), 32'h1);
    idle(40, 1'b1, 1'b1);
    check("break_no_retrigger", 32'(rises), 32'd1);

    // 4-cycle glitch on idle line is rejected
    clear_log();
    idle(4, 1'b0, 1'b1);
    idle(200, 1'b1, 1'b1);
    $display("glitch: rises=%0d", rises);
    check("glitch_rises", 32'(rises), 32'd0);
    check("glitch_valid", 32'(rx_valid), 32'h0);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(20, 1'b1, 1'b1);
    check("post_glitch_data", 32'(got_q[0]), 32'h5A);
    check("post_glitch_ferr", 32'(rise_ferr), 32'h0);

    // rec_en dropped during bit 4, then a full 0x81
    clear_log();
    idle(5 * 16, 1'b0, 1'b1);
    rec_en = 1'b0;
    idle(40, 1'b1, 1'b1);
    rec_en = 1'b1;
    idle(20, 1'b1, 1'b1);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(20, 1'b1, 1'b1);
    $display("rec_en abort: rises=%0d", rises);
    check("recen_rises", 32'(rises), 32'd1);
    check("recen_data", 32'(got_q[0]), 32'h81);

    // Reset mid-frame with valid and overrun set
    send_frame(8'h99, 1'b1, 1'b0);
    send_frame(8'h66, 1'b1, 1'b0);
    check("pre_reset_ovr", 32'(rx_ovr), 32'h1);
    idle(50, 1'b0, 1'b0);
    resetn = 1'b0;
    #1;
    check("midrst_rx_data", 32'(rx_data), 32'h00);
    check("midrst_rx_valid", 32'(rx_valid), 32'h0);
    check("midrst_rx_ferr", 32'(rx_ferr), 32'h0);
    check("midrst_rx_ovr", 32'(rx_ovr), 32'h0);
    uart_rx = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    resetn = 1'b1;
    valid_prev = 1'b0;
    clear_log();
    idle(200, 1'b1, 1'b0);
    $display("post reset: rises=%0d", rises);
    check("post_reset_rises", 32'(rises), 32'd0);
    check("post_reset_valid", 32'(rx_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
